// File: rtl/cv32e40p_id_issue_ctrl_if.sv
// Handshake bundle between the ID issue sequencer and its neighbours:
// decoder classification, EX ready, LSU request/grant, multiplier and
// controller handshakes, plus the sequencer's status outputs.
interface cv32e40p_id_issue_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             instr_valid_i;
   logic             illegal_insn_i;
   logic             sys_insn_i;
   logic             data_req_i;
   logic             mult_multicycle_i;
   logic             halt_id_i;
   logic             flush_i;
   logic             ex_ready_i;
   logic             lsu_gnt_i;
   logic             mult_ready_i;
   logic             sys_ack_i;
   logic             deassert_we_o;
   logic             id_valid_o;
   logic             id_ready_o;
   logic             lsu_req_o;
   logic             mult_start_o;
   logic             sys_req_o;
   logic             sys_illegal_o;
   logic             busy_o;
   logic [CNT_W-1:0] stall_cnt_o;

   // Driving side: decoder / pipeline environment
   modport master (
      output instr_valid_i, illegal_insn_i, sys_insn_i, data_req_i,
             mult_multicycle_i, halt_id_i, flush_i, ex_ready_i,
             lsu_gnt_i, mult_ready_i, sys_ack_i,
      input  deassert_we_o, id_valid_o, id_ready_o, lsu_req_o,
             mult_start_o, sys_req_o, sys_illegal_o, busy_o, stall_cnt_o
   );

   // Sequencer side
   modport slave (
      input  instr_valid_i, illegal_insn_i, sys_insn_i, data_req_i,
             mult_multicycle_i, halt_id_i, flush_i, ex_ready_i,
             lsu_gnt_i, mult_ready_i, sys_ack_i,
      output deassert_we_o, id_valid_o, id_ready_o, lsu_req_o,
             mult_start_o, sys_req_o, sys_illegal_o, busy_o, stall_cnt_o
   );
endinterface

// File: rtl/cv32e40p_id_issue_ctrl.sv
// ID-stage issue sequencer: decides when the decoded instruction leaves ID,
// sequences LSU grant waits, multi-cycle multiplies and sys/illegal hand-off
// to the controller, and drives the decoder's deassert_we.
// The interface instance must be created with the same CNT_W as this module.
module cv32e40p_id_issue_ctrl #(
   parameter int CNT_W      = 16,
   parameter bit MULT_MC_EN = 1'b1
) (
   input logic                     clk,
   input logic                     rst_n,
   cv32e40p_id_issue_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LSU_WAIT  = 2'd1,
      MULT_WAIT = 2'd2,
      SYS_WAIT  = 2'd3
   } state_e;

   state_e           state_reg, state_next;
   logic             grant_seen_reg, grant_seen_next;
   logic             sys_illegal_reg, sys_illegal_next;
   logic             busy_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic go;
   logic mult_mc;
   logic id_valid, id_ready, lsu_req, mult_start, sys_req;

   assign go      = bus.instr_valid_i & ~bus.halt_id_i & ~bus.flush_i;
   assign mult_mc = bus.mult_multicycle_i & MULT_MC_EN;

   // Next-state and Mealy issue/request outputs; flush overrides everything
   always_comb begin
      state_next       = state_reg;
      grant_seen_next  = grant_seen_reg;
      sys_illegal_next = sys_illegal_reg;
      id_valid         = 1'b0;
      id_ready         = 1'b0;
      lsu_req          = 1'b0;
      mult_start       = 1'b0;
      sys_req          = 1'b0;

      case (state_reg)
         RUN: begin
            if (go) begin
               if (bus.illegal_insn_i | bus.sys_insn_i) begin
                  sys_req          = 1'b1;
                  sys_illegal_next = bus.illegal_insn_i;
                  state_next       = SYS_WAIT;
               end else if (bus.data_req_i) begin
                  lsu_req = 1'b1;
                  if (bus.lsu_gnt_i & bus.ex_ready_i) begin
                     id_valid = 1'b1;
                     id_ready = 1'b1;
                  end else begin
                     // A grant that arrives while EX is busy must not be re-requested
                     grant_seen_next = bus.lsu_gnt_i;
                     state_next      = LSU_WAIT;
                  end
               end else if (mult_mc & bus.ex_ready_i) begin
                  mult_start = 1'b1;
                  id_valid   = 1'b1;
                  state_next = MULT_WAIT;
               end else begin
                  id_valid = bus.ex_ready_i;
                  id_ready = bus.ex_ready_i;
               end
            end
         end
         LSU_WAIT: begin
            lsu_req = ~grant_seen_reg;
            if ((bus.lsu_gnt_i | grant_seen_reg) & bus.ex_ready_i) begin
               id_valid        = 1'b1;
               id_ready        = 1'b1;
               grant_seen_next = 1'b0;
               state_next      = RUN;
            end else if (bus.lsu_gnt_i) begin
               grant_seen_next = 1'b1;
            end
         end
         MULT_WAIT: begin
            if (bus.mult_ready_i) begin
               id_ready   = 1'b1;
               state_next = RUN;
            end
         end
         SYS_WAIT: begin
            if (bus.sys_ack_i) begin
               id_ready         = 1'b1;
               sys_illegal_next = 1'b0;
               state_next       = RUN;
            end
         end
         default: state_next = RUN;
      endcase

      if (bus.flush_i) begin
         state_next       = RUN;
         grant_seen_next  = 1'b0;
         sys_illegal_next = 1'b0;
         id_valid         = 1'b0;
         id_ready         = 1'b0;
         lsu_req          = 1'b0;
         mult_start       = 1'b0;
         sys_req          = 1'b0;
      end
   end

   // State, registered status outputs and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= RUN;
         grant_seen_reg  <= 1'b0;
         sys_illegal_reg <= 1'b0;
         busy_reg        <= 1'b0;
         stall_cnt_reg   <= '0;
      end else begin
         state_reg       <= state_next;
         grant_seen_reg  <= grant_seen_next;
         sys_illegal_reg <= sys_illegal_next;
         busy_reg        <= (state_next != RUN);
         if (bus.instr_valid_i & ~id_ready & ~(&stall_cnt_reg))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign bus.deassert_we_o = ~go | (state_reg == SYS_WAIT) |
                              ((state_reg == RUN) & (bus.illegal_insn_i | bus.sys_insn_i));
   assign bus.id_valid_o    = id_valid;
   assign bus.id_ready_o    = id_ready;
   assign bus.lsu_req_o     = lsu_req;
   assign bus.mult_start_o  = mult_start;
   assign bus.sys_req_o     = sys_req;
   assign bus.sys_illegal_o = sys_illegal_reg;
   assign bus.busy_o        = busy_reg;
   assign bus.stall_cnt_o   = stall_cnt_reg;

endmodule

// File: tb/tb_cv32e40p_id_issue_ctrl.sv
// Self-checking bench for the ID issue sequencer (CNT_W=4 to reach saturation).
// Stimulus vector bits: iv ill sys dreq mmc halt flush exr gnt mrdy ack
// Output vector bits:   dwe vld rdy lreq mst sreq sill busy cnt[3:0]
module tb_cv32e40p_id_issue_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [11:0] exp_q[$];
   logic [11:0] got, want;

   always #5 clk = ~clk;

   cv32e40p_id_issue_ctrl_if #(.CNT_W(4)) bus ();

   cv32e40p_id_issue_ctrl #(.CNT_W(4), .MULT_MC_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic apply(input logic [10:0] v);
      bus.instr_valid_i     = v[10];
      bus.illegal_insn_i    = v[9];
      bus.sys_insn_i        = v[8];
      bus.data_req_i        = v[7];
      bus.mult_multicycle_i = v[6];
      bus.halt_id_i         = v[5];
      bus.flush_i           = v[4];
      bus.ex_ready_i        = v[3];
      bus.lsu_gnt_i         = v[2];
      bus.mult_ready_i      = v[1];
      bus.sys_ack_i         = v[0];
   endtask

   function automatic logic [11:0] sample();
      return {bus.deassert_we_o, bus.id_valid_o, bus.id_ready_o, bus.lsu_req_o,
              bus.mult_start_o, bus.sys_req_o, bus.sys_illegal_o, bus.busy_o,
              bus.stall_cnt_o};
   endfunction

   // Reset, release in the low clock phase, return aligned just after a posedge
   task automatic do_reset();
      rst_n = 1'b0;
      apply(11'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      apply(11'b0);
      exp_q.push_back({8'b1000_0000, 4'd0});
      #1;
      got = sample(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL reset_idle got=%b want=%b", got, want); end
      else $display("reset_idle ok %b", got);
      // Load request under reset: Mealy request visible, state held in RUN across an edge
      apply(11'b1_0_0_1_0_0_0_1_0_0_0);
      exp_q.push_back({8'b0001_0000, 4'd0});
      @(posedge clk);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL reset_hold got=%b want=%b", got, want); end
      else $display("reset_hold ok %b", got);
   endtask

   task automatic test_alu();
      logic [10:0] stim [6];
      logic [11:0] expv [6];
      do_reset();
      stim = '{11'b1_0_0_0_0_0_0_1_0_0_0, 11'b1_0_0_0_0_0_0_1_0_0_0,
               11'b1_0_0_0_0_0_0_1_0_0_0, 11'b1_0_0_0_0_0_0_1_0_0_0,
               11'b1_0_0_0_0_0_0_0_0_0_0, 11'b0};
      expv = '{{8'b0110_0000, 4'd0}, {8'b0110_0000, 4'd0}, {8'b0110_0000, 4'd0},
               {8'b0110_0000, 4'd0}, {8'b0000_0000, 4'd0}, {8'b1000_0000, 4'd1}};
      for (int c = 0; c < 6; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL alu c%0d got=%b want=%b", c, got, want); end
         else $display("alu c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load();
      logic [10:0] stim [4];
      logic [11:0] expv [4];
      do_reset();
      stim = '{11'b1_0_0_1_0_0_0_1_0_0_0, 11'b1_0_0_1_0_0_0_1_0_0_0,
               11'b1_0_0_1_0_0_0_1_1_0_0, 11'b0};
      expv = '{{8'b0001_0000, 4'd0}, {8'b0001_0001, 4'd1},
               {8'b0111_0001, 4'd2}, {8'b1000_0000, 4'd2}};
      for (int c = 0; c < 4; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL load c%0d got=%b want=%b", c, got, want); end
         else $display("load c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   // Grant arrives while EX is busy; halt during the wait does not abort it
   task automatic test_lsu_grant_seen();
      logic [10:0] stim [4];
      logic [11:0] expv [4];
      do_reset();
      stim = '{11'b1_0_0_1_0_0_0_0_1_0_0, 11'b1_0_0_1_0_1_0_0_0_0_0,
               11'b1_0_0_1_0_0_0_1_0_0_0, 11'b0};
      expv = '{{8'b0001_0000, 4'd0}, {8'b1000_0001, 4'd1},
               {8'b0110_0001, 4'd2}, {8'b1000_0000, 4'd2}};
      for (int c = 0; c < 4; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL gnt_seen c%0d got=%b want=%b", c, got, want); end
         else $display("gnt_seen c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mult();
      logic [10:0] stim [6];
      logic [11:0] expv [6];
      do_reset();
      stim = '{11'b1_0_0_0_1_0_0_1_0_0_0, 11'b1_0_0_0_1_0_0_1_0_0_0,
               11'b1_0_0_0_1_0_0_1_0_0_0, 11'b1_0_0_0_1_0_0_1_0_0_0,
               11'b1_0_0_0_1_0_0_1_0_1_0, 11'b0};
      expv = '{{8'b0100_1000, 4'd0}, {8'b0000_0001, 4'd1}, {8'b0000_0001, 4'd2},
               {8'b0000_0001, 4'd3}, {8'b0010_0001, 4'd4}, {8'b1000_0000, 4'd4}};
      for (int c = 0; c < 6; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL mult c%0d got=%b want=%b", c, got, want); end
         else $display("mult c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      logic [10:0] stim [5];
      logic [11:0] expv [5];
      do_reset();
      stim = '{11'b1_1_0_0_0_0_0_1_0_0_0, 11'b1_1_0_0_0_0_0_1_0_0_0,
               11'b1_1_0_0_0_0_0_1_0_0_0, 11'b1_1_0_0_0_0_0_1_0_0_1, 11'b0};
      expv = '{{8'b1000_0100, 4'd0}, {8'b1000_0011, 4'd1}, {8'b1000_0011, 4'd2},
               {8'b1010_0011, 4'd3}, {8'b1000_0000, 4'd3}};
      for (int c = 0; c < 5; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL illegal c%0d got=%b want=%b", c, got, want); end
         else $display("illegal c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   // ecall-like sys insn; ack together with flush loses; ack in RUN ignored
   task automatic test_sys_flush();
      logic [10:0] stim [3];
      logic [11:0] expv [3];
      do_reset();
      stim = '{11'b1_0_1_0_0_0_0_1_0_0_0, 11'b1_0_1_0_0_0_1_1_0_0_1, 11'b0_0_0_0_0_0_0_0_0_0_1};
      expv = '{{8'b1000_0100, 4'd0}, {8'b1000_0001, 4'd1}, {8'b1000_0000, 4'd2}};
      for (int c = 0; c < 3; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL sys_flush c%0d got=%b want=%b", c, got, want); end
         else $display("sys_flush c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_flush();
      logic [10:0] stim [4];
      logic [11:0] expv [4];
      do_reset();
      stim = '{11'b1_0_0_1_0_0_0_1_0_0_0, 11'b1_0_0_1_0_0_0_1_0_0_0,
               11'b1_0_0_1_0_0_1_1_0_0_0, 11'b0};
      expv = '{{8'b0001_0000, 4'd0}, {8'b0001_0001, 4'd1},
               {8'b1000_0001, 4'd2}, {8'b1000_0000, 4'd3}};
      for (int c = 0; c < 4; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL load_flush c%0d got=%b want=%b", c, got, want); end
         else $display("load_flush c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] stim [5];
      logic [11:0] expv [5];
      do_reset();
      stim = '{11'b1_0_0_0_0_0_0_1_0_0_0, 11'b1_0_0_1_0_0_0_1_1_0_0,
               11'b1_0_0_0_1_0_0_1_0_0_0, 11'b1_0_0_0_1_0_0_1_0_1_0,
               11'b1_0_0_0_0_0_0_1_0_0_0};
      expv = '{{8'b0110_0000, 4'd0}, {8'b0111_0000, 4'd0}, {8'b0100_1000, 4'd0},
               {8'b0010_0001, 4'd1}, {8'b0110_0000, 4'd1}};
      for (int c = 0; c < 5; c++) begin
         apply(stim[c]);
         exp_q.push_back(expv[c]);
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL b2b c%0d got=%b want=%b", c, got, want); end
         else $display("b2b c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
   endtask

   // Load never granted, EX stalled: counter saturates, async reset clears at once
   task automatic test_saturate();
      logic [3:0] cnt;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         apply(11'b1_0_0_1_0_0_0_0_0_0_0);
         cnt = (c > 15) ? 4'd15 : 4'(c);
         exp_q.push_back({(c == 0) ? 8'b0001_0000 : 8'b0001_0001, cnt});
         @(negedge clk);
         got = sample(); want = exp_q.pop_front(); n_vec++;
         if (got !== want) begin n_err++; $display("FAIL sat c%0d got=%b want=%b", c, got, want); end
         else $display("sat c%0d ok %b", c, got);
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      exp_q.push_back({8'b0001_0000, 4'd0});
      #1;
      got = sample(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL async_rst got=%b want=%b", got, want); end
      else $display("async_rst ok %b", got);
      do_reset();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_lsu_grant_seen();
      test_mult();
      test_illegal();
      test_sys_flush();
      test_load_flush();
      test_back_to_back();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cv32e40p_id_issue_ctrl.md
Name: cv32e40p_id_issue_ctrl

Overview:
Issue sequencer for the ID stage. It takes the decoder's per-instruction classification and decides when the instruction leaves ID, and it drives the decoder's deassert_we input. It sequences multi-cycle cases: LSU grant wait, multi-cycle multiply, and system/illegal instructions handed to the controller. It sits between cv32e40p_decoder, the EX stage ready and the LSU request/grant interface.

Parameters:
CNT_W, 16, width of the saturating ID stall-cycle counter
MULT_MC_EN, 1, 1 = mult_multicycle_i uses MULT_WAIT; 0 = all multiplies treated as single-cycle

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instr_valid_i  in  1  valid instruction present in ID
illegal_insn_i  in  1  decoder illegal_insn (decoded with deassert_we=0)
sys_insn_i  in  1  OR of decoder ebrk/ecall/mret/uret/dret/fencei/wfi *_dec
data_req_i  in  1  decoder data_req
mult_multicycle_i  in  1  multiply needing more than one EX cycle (mulh/mac)
halt_id_i  in  1  controller halt of ID
flush_i  in  1  synchronous flush of ID
ex_ready_i  in  1  EX can accept an instruction
lsu_gnt_i  in  1  LSU accepted the request
mult_ready_i  in  1  multiplier finished the multi-cycle op
sys_ack_i  in  1  controller finished handling the sys/illegal instruction
deassert_we_o  out  1  to decoder deassert_we_i
id_valid_o  out  1  instruction issued to EX this cycle
id_ready_o  out  1  ID accepts the next instruction this cycle
lsu_req_o  out  1  LSU request
mult_start_o  out  1  one-cycle multiplier start pulse
sys_req_o  out  1  one-cycle request to the controller
sys_illegal_o  out  1  registered: the pending sys request is an illegal instruction
busy_o  out  1  state != RUN
stall_cnt_o  out  CNT_W  saturating count of stalled ID cycles

Behaviour:
- States: RUN, LSU_WAIT, MULT_WAIT, SYS_WAIT. Encoding is free.
- Reset (async, rst_n=0): state=RUN, stall_cnt_o=0, sys_illegal_o=0. The Mealy outputs then follow RUN equations: with instr_valid_i=0 they are all 0 except deassert_we_o=1.
- Let go = instr_valid_i & ~halt_id_i & ~flush_i.
- deassert_we_o = ~go | (state==SYS_WAIT) | (state==RUN & (illegal_insn_i|sys_insn_i)).
- RUN, decode priority:
  1. illegal_insn_i | sys_insn_i: sys_req_o=1 for one cycle; sys_illegal_o<=illegal_insn_i; next state SYS_WAIT.
  2. data_req_i: lsu_req_o=1.
     - If lsu_gnt_i & ex_ready_i: id_valid_o=id_ready_o=1, stay RUN.
     - Otherwise: next state LSU_WAIT.
  3. mult_multicycle_i & MULT_MC_EN & ex_ready_i: mult_start_o=1, id_valid_o=1, next state MULT_WAIT. If ex_ready_i=0, wait in RUN.
  4. Otherwise: id_valid_o=id_ready_o=ex_ready_i.
  - With go=0: no outputs asserted except deassert_we_o; stay RUN.
- LSU_WAIT: lsu_req_o held at 1 until the grant (request never withdrawn except on flush). On lsu_gnt_i & ex_ready_i: id_valid_o=id_ready_o=1, next state RUN. A grant without ex_ready_i keeps waiting with lsu_req_o=0 and a grant_seen flag set; completion then occurs on ex_ready_i.
- MULT_WAIT: id_ready_o=0. On mult_ready_i: id_ready_o=1, next state RUN.
- SYS_WAIT: all requests 0, deassert_we_o=1. On sys_ack_i: id_ready_o=1, next state RUN, sys_illegal_o<=0.
- flush_i has highest priority in every state:
  - next state RUN, grant_seen and sys_illegal_o cleared.
  - lsu_req_o, mult_start_o, sys_req_o forced 0 that cycle.
  - id_valid_o=0.
- halt_id_i in a wait state does not abort the wait; it only blocks new issue from RUN.
- stall_cnt_o increments when instr_valid_i & ~id_ready_o. It saturates at 2^CNT_W-1 and is cleared only by reset.
- busy_o = (state != RUN).
- Simultaneous events: sys_ack_i and flush_i together → flush wins (id_ready_o=0). An acknowledge arriving outside SYS_WAIT is ignored.

Test Plan:
- ALU op, instr_valid=1, ex_ready=1 for 4 cycles → id_valid=id_ready=1 each cycle, deassert_we=0, stall_cnt=0.
- Load, gnt arrives on the 3rd cycle → lsu_req=1 for cycles 0-2, id_valid only in cycle 2, busy=1 in cycles 1-2, stall_cnt=2.
- mulh with mult_ready after 4 cycles → mult_start pulses in cycle 0, id_ready=1 only in cycle 4, stall_cnt=4.
- Illegal instruction, sys_ack in cycle 3 → sys_req pulse in cycle 0, sys_illegal=1 in cycles 1-3, deassert_we=1 in cycles 0-3, id_ready in cycle 3, then 0 afterwards.
- Load waiting, flush_i in cycle 2 → lsu_req=0 in cycle 2, state RUN in cycle 3, no id_valid.
- Set CNT_W=4 and hold ex_ready=0 for 20 cycles → stall_cnt saturates at 15. Assert rst_n=0 mid-wait → state RUN and stall_cnt=0 immediately.
